l2_access_ctrl: RTL and testbench

- Initiator-side controller for one port of the dual-port L2 block memory. It has 128-bit blocks, 16-bit byte enables and a tag/idx/word/offset address.
- Accepts block read/write requests from an L1 client over a valid/ready handshake and drives the L2 port's read/write strobes, address, data and byte enables. It samples the L2 hit and read data.
- On a read miss, fetches the block from main memory, fills L2 and then responds.
- Writes are write-through: L2 never holds dirty data.
- One instance sits in front of each L2 port: port 1 serves the data cache, port 2 serves the instruction cache.

---
 rtl/l2_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_l2_access_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_access_ctrl.sv
// One-port L2 initiator: serves L1 block reads (with main-memory fetch and fill on miss) and write-through writes.
// Define L2_ACCESS_PERF_CNT_EN to add saturating read hit/miss counters (hit_cnt_o, miss_cnt_o).
module l2_access_ctrl #(
    parameter int BLOCK_W = 128,
    parameter int TAG_W   = 7,
    parameter int IDX_W   = 8,
    parameter int WORD_W  = 2,
    parameter int OFF_W   = 2,
    parameter int L2_LAT  = 1,
    localparam int ADDR_W = TAG_W + IDX_W + WORD_W + OFF_W,
    localparam int BE_W   = BLOCK_W / 8,
    localparam int MEM_AW = ADDR_W - WORD_W - OFF_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [BLOCK_W-1:0]  req_wdata_i,
    input  logic [BE_W-1:0]     req_be_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [BLOCK_W-1:0]  resp_data_o,
    output logic                resp_hit_o,
    output logic                l2_read_o,
    output logic                l2_write_o,
    output logic [ADDR_W-1:0]   l2_addr_o,
    output logic [BLOCK_W-1:0]  l2_wdata_o,
    output logic [BE_W-1:0]     l2_be_o,
    input  logic [BLOCK_W-1:0]  l2_rdata_i,
    input  logic                l2_hit_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [MEM_AW-1:0]   mem_addr_o,
    output logic [BLOCK_W-1:0]  mem_wdata_o,
    output logic [BE_W-1:0]     mem_be_o,
    input  logic                mem_ack_i,
    input  logic [BLOCK_W-1:0]  mem_rdata_i
`ifdef L2_ACCESS_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);

    localparam int LAT_CW = (L2_LAT > 1) ? $clog2(L2_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_L2_RD, S_L2_WAIT, S_MEM_RD, S_L2_FILL, S_L2_WR, S_MEM_WR, S_RESP
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [BLOCK_W-1:0]  r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [BLOCK_W-1:0]  r_rdata;
    logic                r_hit;
    logic [LAT_CW-1:0]   r_lat_cnt;
    logic                w_accept;
    logic                w_lat_done;
    logic                w_decide;

    assign w_accept   = (r_state == S_IDLE) && req_valid_i;
    assign w_lat_done = (r_lat_cnt == LAT_CW'(L2_LAT - 1));
    assign w_decide   = (r_state == S_L2_WAIT) && w_lat_done;

    // NOTE: every output and the next state get a default before the case, so no path infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_data_o  = '0;
        resp_hit_o   = 1'b0;
        l2_read_o    = 1'b0;
        l2_write_o   = 1'b0;
        l2_addr_o    = (r_state == S_IDLE) ? '0 : r_addr;
        l2_wdata_o   = '0;
        l2_be_o      = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_be_o     = '0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_state_nxt = req_we_i ? S_L2_WR : S_L2_RD;
            end
            S_L2_RD: begin
                l2_read_o   = 1'b1;
                w_state_nxt = S_L2_WAIT;
            end
            S_L2_WAIT: begin
                if (w_lat_done) w_state_nxt = l2_hit_i ? S_RESP : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_addr[ADDR_W-1:WORD_W+OFF_W];
                if (mem_ack_i) w_state_nxt = S_L2_FILL;
            end
            S_L2_FILL: begin
                l2_write_o  = 1'b1;
                l2_wdata_o  = r_rdata;
                l2_be_o     = '1;
                w_state_nxt = S_RESP;
            end
            S_L2_WR: begin
                l2_write_o  = 1'b1;
                l2_wdata_o  = r_wdata;
                l2_be_o     = r_be;
                w_state_nxt = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_addr[ADDR_W-1:WORD_W+OFF_W];
                mem_wdata_o = r_wdata;
                mem_be_o    = r_be;
                if (mem_ack_i) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_data_o  = r_rdata;
                resp_hit_o   = r_hit;
                if (resp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rdata   <= '0;
            r_hit     <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr    <= req_addr_i;
                r_wdata   <= req_wdata_i;
                r_be      <= req_be_i;
                r_rdata   <= '0;
                r_hit     <= 1'b0;
                r_lat_cnt <= '0;
            end
            if ((r_state == S_L2_WAIT) && !w_lat_done) r_lat_cnt <= r_lat_cnt + LAT_CW'(1);
            if (w_decide && l2_hit_i) begin
                r_rdata <= l2_rdata_i;
                r_hit   <= 1'b1;
            end
            // The fetched block doubles as the fill data and the miss response.
            if ((r_state == S_MEM_RD) && mem_ack_i) r_rdata <= mem_rdata_i;
        end
    end

`ifdef L2_ACCESS_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_decide) begin
            if (l2_hit_i && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (!l2_hit_i && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l2_access_ctrl.sv
// Randomized bench for l2_access_ctrl: L2 and main-memory device models drive the DUT, and a
// transaction-level reference (block store semantics) predicts every response.
module tb_l2_access_ctrl;

    localparam int L2_LAT = 3;

    logic          clk;
    logic          rst_ni;
    logic          req_valid, req_ready_o, req_we;
    logic [18:0]   req_addr;
    logic [127:0]  req_wdata;
    logic [15:0]   req_be;
    logic          resp_valid_o, resp_ready, resp_hit_o;
    logic [127:0]  resp_data_o;
    logic          l2_read_o, l2_write_o, l2_hit_i;
    logic [18:0]   l2_addr_o;
    logic [127:0]  l2_wdata_o, l2_rdata_i;
    logic [15:0]   l2_be_o;
    logic          mem_req_o, mem_we_o, mem_ack_i;
    logic [14:0]   mem_addr_o;
    logic [127:0]  mem_wdata_o, mem_rdata_i;
    logic [15:0]   mem_be_o;
`ifdef L2_ACCESS_PERF_CNT_EN
    logic [31:0]   hit_cnt, miss_cnt;
`endif

    l2_access_ctrl #(.L2_LAT(L2_LAT)) dut (
`ifdef L2_ACCESS_PERF_CNT_EN
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
`endif
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data_o), .resp_hit_o(resp_hit_o),
        .l2_read_o(l2_read_o), .l2_write_o(l2_write_o), .l2_addr_o(l2_addr_o),
        .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o), .l2_rdata_i(l2_rdata_i), .l2_hit_i(l2_hit_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_hit_ref = 0;
    int n_miss_ref = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Device contents (changed only by DUT strobes) and reference contents (changed by transaction meaning).
    logic [127:0] l2_dev[int];
    logic [127:0] l2_ref[int];
    logic [127:0] mem_dev[int];
    logic [127:0] mem_ref[int];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] mem_init(input int k);
        logic [14:0] kk;
        kk = k[14:0];
        return {4{kk, 17'h1abcd}};
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old_d, input logic [127:0] new_d,
                                           input logic [15:0] be);
        logic [127:0] r;
        r = old_d;
        for (int b = 0; b < 16; b++) if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

    function automatic int key_of(input logic [18:0] a);
        return int'(a[18:4]);
    endfunction

    function automatic logic [18:0] rand_addr();
        logic [6:0] tag;
        tag = ($urandom_range(0, 1) == 1) ? 7'd5 : 7'd6;
        return {tag, 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
    endfunction

    // L2 device: answers a read with real hit/data only in the cycle ending L2_LAT edges after the strobe.
    int l2_pend = 0;
    int l2_key = 0;
    initial begin
        bit valid_now;
        int k;
        l2_hit_i   = 1'b0;
        l2_rdata_i = '0;
        forever begin
            @(negedge clk);
            valid_now = 1'b0;
            if (!rst_ni) l2_pend = 0;
            else if (l2_read_o) begin
                l2_pend = L2_LAT;
                l2_key  = key_of(l2_addr_o);
            end else if (l2_pend > 0) begin
                l2_pend--;
                valid_now = (l2_pend == 0);
            end
            if (rst_ni && l2_write_o) begin
                k = key_of(l2_addr_o);
                if (l2_dev.exists(k)) l2_dev[k] = merge(l2_dev[k], l2_wdata_o, l2_be_o);
                else if (l2_be_o == 16'hFFFF) l2_dev[k] = l2_wdata_o;
            end
            if (valid_now) begin
                l2_hit_i   = l2_dev.exists(l2_key);
                l2_rdata_i = l2_hit_i ? l2_dev[l2_key] : rnd128();
            end else begin
                l2_hit_i   = 1'($urandom_range(0, 1));
                l2_rdata_i = rnd128();
            end
        end
    end

    // Main-memory device: acks after a chosen delay (0 = same cycle), plus spurious acks while idle.
    int  m_force = -1;
    int  m_last_delay = 0;
    int  m_wait = 0;
    bit  m_busy = 0;
    bit  m_acked = 0;
    initial begin
        int k;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                m_busy = 0; m_acked = 0; mem_ack_i = 1'b0;
            end else if (mem_req_o && !m_acked) begin
                if (!m_busy) begin
                    m_busy = 1;
                    m_wait = (m_force >= 0) ? m_force : int'($urandom_range(0, 3));
                    m_last_delay = m_wait;
                end else m_wait--;
                mem_ack_i   = 1'b0;
                mem_rdata_i = rnd128();
                if (m_wait == 0) begin
                    k = int'(mem_addr_o);
                    if (!mem_dev.exists(k)) mem_dev[k] = mem_init(k);
                    if (mem_we_o) mem_dev[k] = merge(mem_dev[k], mem_wdata_o, mem_be_o);
                    mem_rdata_i = mem_dev[k];
                    mem_ack_i   = 1'b1;
                    m_busy = 0; m_acked = 1;
                end
            end else begin
                m_acked     = 0;
                mem_ack_i   = !mem_req_o && ($urandom_range(0, 7) == 0);
                mem_rdata_i = rnd128();
            end
        end
    end

    task automatic run_txn(input logic we, input logic [18:0] addr, input logic [127:0] wdata,
                           input logic [15:0] be, input int hold, input bit pulse);
        int k, n_rd, n_wr, n_mq, lat, exp_lat;
        logic [127:0] exp_d, cap_d, mv;
        logic exp_h, cap_h;
        bit seen, bad_addr, bad_wr, bad_mem, bad_both, unstable;
        k = key_of(addr);
        mv = mem_ref.exists(k) ? mem_ref[k] : mem_init(k);
        if (we) begin
            exp_d = '0; exp_h = 1'b0;
            mem_ref[k] = merge(mv, wdata, be);
            if (l2_ref.exists(k)) l2_ref[k] = merge(l2_ref[k], wdata, be);
            else if (be == 16'hFFFF) l2_ref[k] = wdata;
        end else if (l2_ref.exists(k)) begin
            exp_d = l2_ref[k]; exp_h = 1'b1; n_hit_ref++;
        end else begin
            exp_d = mv; exp_h = 1'b0; n_miss_ref++;
            l2_ref[k] = mv;
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        check("req_ready_idle", req_ready_o, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        n_rd = 0; n_wr = 0; n_mq = 0; lat = 0; seen = 0;
        bad_addr = 0; bad_wr = 0; bad_mem = 0; bad_both = 0;
        for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
            @(negedge clk);
            if (l2_read_o && l2_write_o) bad_both = 1;
            if (l2_read_o) begin
                n_rd++;
                if (l2_addr_o !== addr) bad_addr = 1;
            end
            if (l2_write_o) begin
                n_wr++;
                if (l2_addr_o !== addr) bad_addr = 1;
                if (we ? (l2_wdata_o !== wdata || l2_be_o !== be)
                       : (l2_wdata_o !== exp_d || l2_be_o !== 16'hFFFF)) bad_wr = 1;
            end
            if (mem_req_o) begin
                n_mq++;
                if (mem_addr_o !== addr[18:4] || mem_we_o !== we) bad_mem = 1;
                if (we && (mem_wdata_o !== wdata || mem_be_o !== be)) bad_mem = 1;
            end
            if (resp_valid_o) begin
                seen = 1; lat = cyc - 1;
            end
        end
        check("resp_arrived", seen, 1'b1);
        if (!seen) return;

        check("resp_data", resp_data_o, exp_d);
        check("resp_hit", resp_hit_o, exp_h);
        exp_lat = we ? m_last_delay + 2 : (exp_h ? L2_LAT + 1 : L2_LAT + m_last_delay + 3);
        check("resp_latency", lat, exp_lat);
        check("l2_read_cycles", n_rd, we ? 0 : 1);
        check("l2_write_cycles", n_wr, (we || !exp_h) ? 1 : 0);
        check("mem_req_cycles", n_mq, (we || !exp_h) ? m_last_delay + 1 : 0);
        check("l2_addr_ok", bad_addr, 1'b0);
        check("l2_wr_payload_ok", bad_wr, 1'b0);
        check("mem_payload_ok", bad_mem, 1'b0);
        check("rd_wr_exclusive", bad_both, 1'b0);

        cap_d = resp_data_o; cap_h = resp_hit_o; unstable = 0;
        for (int i = 0; i < hold; i++) begin
            req_valid = pulse && (i == 1);
            @(negedge clk);
            if (!resp_valid_o || resp_data_o !== cap_d || resp_hit_o !== cap_h || req_ready_o) unstable = 1;
        end
        req_valid = 1'b0;
        if (hold > 0) check("resp_held_stable", unstable, 1'b0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("back_to_idle", {resp_valid_o, req_ready_o}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_ctrl", {req_ready_o, resp_valid_o, resp_hit_o, l2_read_o, l2_write_o, mem_req_o, mem_we_o},
              7'b1000000);
        check("rst_data", resp_data_o | l2_wdata_o | mem_wdata_o, '0);
        check("rst_addr_be", {l2_addr_o, mem_addr_o, l2_be_o, mem_be_o}, '0);
        rst_ni = 1'b1;

        l2_dev[key_of({7'd5, 8'd1, 4'd0})] = 128'd15;  l2_ref[key_of({7'd5, 8'd1, 4'd0})] = 128'd15;
        l2_dev[key_of({7'd5, 8'd0, 4'd0})] = 128'h55;  l2_ref[key_of({7'd5, 8'd0, 4'd0})] = 128'h55;
        mem_dev[key_of({7'd6, 8'd6, 4'd0})] = 128'd30; mem_ref[key_of({7'd6, 8'd6, 4'd0})] = 128'd30;

        // Reset while waiting on main memory: request must drop at once and no response follows.
        m_force = 50;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = {7'd6, 8'd9, 4'd0};
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk);
        check("mreq_before_rst", mem_req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 check("mreq_async_drop", {mem_req_o, req_ready_o}, 2'b01);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid_o || mem_req_o) seen = 1;
        end
        check("no_resp_after_rst", seen, 1'b0);

        m_force = -1;
        run_txn(1'b0, {7'd5, 8'd1, 2'd0, 2'd0}, '0, '0, 0, 0);
        m_force = 3;
        run_txn(1'b0, {7'd6, 8'd6, 2'd1, 2'd2}, '0, '0, 0, 0);
        m_force = 2;
        run_txn(1'b1, {7'd5, 8'd0, 2'd0, 2'd0}, 128'd40, 16'hFFFF, 0, 0);
        m_force = -1;
        run_txn(1'b0, {7'd5, 8'd0, 2'd0, 2'd0}, '0, '0, 5, 1);
        m_force = 0;
        run_txn(1'b0, {7'd6, 8'd7, 2'd0, 2'd0}, '0, '0, 0, 0);
        m_force = -1;

        for (int t = 0; t < 60; t++) begin
            logic [18:0] a;
            logic [15:0] be;
            int ek;
            if ($urandom_range(0, 5) == 0) begin
                ek = key_of(rand_addr());
                l2_dev.delete(ek);
                l2_ref.delete(ek);
            end
            a  = rand_addr();
            be = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            run_txn($urandom_range(0, 2) == 0, a, rnd128(), be, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

`ifdef L2_ACCESS_PERF_CNT_EN
        check("hit_cnt", hit_cnt, n_hit_ref);
        check("miss_cnt", miss_cnt, n_miss_ref);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
